// File: rtl/psum_accum.sv
// psum_accum: pops MAC-array partial-sum words and accumulates them per row across passes, optional ReLU on last pass.
// Latency: a popped word lands in the buffer at the pop edge; rd_data is registered, one cycle after rd_en.
// Backpressure: pops only while fifo_valid in RUN (fifo_rd = RUN & fifo_valid); stalls indefinitely when the FIFO is empty.
//
// Ports:
//   clk, reset              rising-edge clock, asynchronous active-high reset
//   start                   one-cycle pulse, accepted only in IDLE; latches row_last/pass_last/relu_en
//   fifo_valid/fifo_data    show-ahead FIFO head, lane i = bits [i*psum_bw +: psum_bw]
//   fifo_rd                 pop strobe, data consumed in the same cycle
//   busy, done              busy in RUN/DONE (registered), done pulses for one cycle after the final write
//   rd_en/rd_addr/rd_data   synchronous buffer read port, returns pre-write data on a same-row collision
module psum_accum #(
   parameter int col     = 8,
   parameter int psum_bw = 16,
   parameter int depth   = 16,
   parameter int aw      = 4,
   parameter int pw      = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic [aw-1:0]          row_last,
   input  logic [pw-1:0]          pass_last,
   input  logic                   relu_en,
   input  logic                   fifo_valid,
   input  logic [col*psum_bw-1:0] fifo_data,
   output logic                   fifo_rd,
   output logic                   busy,
   output logic                   done,
   input  logic                   rd_en,
   input  logic [aw-1:0]          rd_addr,
   output logic [col*psum_bw-1:0] rd_data
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                 state, state_nxt;
   logic [aw-1:0]          row_last_q, row_cnt;
   logic [pw-1:0]          pass_last_q, pass_cnt;
   logic                   relu_en_q;
   logic [col*psum_bw-1:0] mem [depth];
   logic [col*psum_bw-1:0] cur_row, wr_word;
   logic                   last_row, last_pass;

   assign last_row  = (row_cnt == row_last_q);
   assign last_pass = (pass_cnt == pass_last_q);

   // state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (fifo_rd && last_row && last_pass) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // outputs decoded from state
   always_comb begin
      fifo_rd = (state == RUN) && fifo_valid;
      done    = (state == DONE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) busy <= 1'b0;
      else       busy <= (state_nxt != IDLE);
   end

   // config latch and row/pass counters
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         row_last_q  <= '0;
         pass_last_q <= '0;
         relu_en_q   <= 1'b0;
         row_cnt     <= '0;
         pass_cnt    <= '0;
      end else if (state == IDLE && start) begin
         row_last_q  <= row_last;
         pass_last_q <= pass_last;
         relu_en_q   <= relu_en;
         row_cnt     <= '0;
         pass_cnt    <= '0;
      end else if (fifo_rd) begin
         if (last_row) begin
            row_cnt <= '0;
            // on the final pop RUN exits, so the pass counter stays put
            if (!last_pass) pass_cnt <= pass_cnt + pw'(1);
         end else begin
            row_cnt <= row_cnt + aw'(1);
         end
      end
   end

   assign cur_row = mem[row_cnt];

   // per-lane accumulate: first pass overwrites, later passes add with
   // saturation; ReLU is applied to the saturated result on the final pass
   for (genvar i = 0; i < col; i++) begin : g_lane
      logic [psum_bw-1:0] old_l, new_l, sat_l;
      logic [psum_bw:0]   sum_l;

      assign old_l = cur_row[i*psum_bw +: psum_bw];
      assign new_l = fifo_data[i*psum_bw +: psum_bw];
      assign sum_l = {old_l[psum_bw-1], old_l} + {new_l[psum_bw-1], new_l};

      always_comb begin
         if (pass_cnt == '0)
            sat_l = new_l;
         else if (sum_l[psum_bw] != sum_l[psum_bw-1])
            // sign of the wide sum picks the rail
            sat_l = sum_l[psum_bw] ? {1'b1, {(psum_bw-1){1'b0}}} : {1'b0, {(psum_bw-1){1'b1}}};
         else
            sat_l = sum_l[psum_bw-1:0];
      end

      assign wr_word[i*psum_bw +: psum_bw] =
         (last_pass && relu_en_q && sat_l[psum_bw-1]) ? '0 : sat_l;
   end

   // accumulation buffer
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int r = 0; r < depth; r++) mem[r] <= '0;
      end else if (fifo_rd) begin
         mem[row_cnt] <= wr_word;
      end
   end

   // read port: sampled before the same-edge write lands
   always_ff @(posedge clk or posedge reset) begin
      if (reset)      rd_data <= '0;
      else if (rd_en) rd_data <= mem[rd_addr];
   end

endmodule

// File: tb/tb_psum_accum.sv
// tb_psum_accum: directed stimulus against psum_accum with a reference model and read scoreboard.
// Latency: expected read data is queued when rd_en is driven and compared one cycle later.
// Backpressure: fifo_valid is toggled to exercise stalls; fifo_rd checked every cycle.
module tb_psum_accum;

   localparam int W = 128;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [3:0]    row_last;
   logic [3:0]    pass_last;
   logic          relu_en;
   logic          fifo_valid;
   logic [W-1:0]  fifo_data;
   logic          fifo_rd;
   logic          busy;
   logic          done;
   logic          rd_en;
   logic [3:0]    rd_addr;
   logic [W-1:0]  rd_data;

   psum_accum dut (
      .clk(clk), .reset(reset), .start(start), .row_last(row_last),
      .pass_last(pass_last), .relu_en(relu_en), .fifo_valid(fifo_valid),
      .fifo_data(fifo_data), .fifo_rd(fifo_rd), .busy(busy), .done(done),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;

   // reference model
   int           m_state;  // 0 idle, 1 run, 2 done
   int           m_row, m_pass, m_rl, m_pl;
   logic         m_relu;
   logic [W-1:0] m_mem [16];
   logic [W-1:0] sb [$];

   task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic logic [W-1:0] mk(input int base, input int stp);
      logic [W-1:0] w;
      int lv;
      w = '0;
      for (int i = 0; i < 8; i++) begin
         lv = base + stp * i;
         w[i*16 +: 16] = lv[15:0];
      end
      return w;
   endfunction

   task automatic m_reset();
      m_state = 0; m_row = 0; m_pass = 0; m_rl = 0; m_pl = 0; m_relu = 1'b0;
      for (int r = 0; r < 16; r++) m_mem[r] = '0;
      sb.delete();
   endtask

   task automatic m_pop(input logic [W-1:0] d);
      int a, b, s;
      for (int i = 0; i < 8; i++) begin
         a = int'($signed(m_mem[m_row][i*16 +: 16]));
         b = int'($signed(d[i*16 +: 16]));
         s = (m_pass == 0) ? b : a + b;
         if (s > 32767)  s = 32767;
         if (s < -32768) s = -32768;
         if (m_pass == m_pl && m_relu && s < 0) s = 0;
         m_mem[m_row][i*16 +: 16] = s[15:0];
      end
   endtask

   // one clock cycle: compare pending read, drive, check, advance model
   task automatic step(input logic v, input logic [W-1:0] d, input logic re, input int ra, input logic st);
      logic [W-1:0] e;
      @(negedge clk);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk("rd_data", rd_data, e);
      end
      fifo_valid = v; fifo_data = d; rd_en = re; rd_addr = ra[3:0]; start = st;
      #1;
      chk("fifo_rd", W'(fifo_rd), W'(m_state == 1 && v));
      chk("busy",    W'(busy),    W'(m_state != 0));
      chk("done",    W'(done),    W'(m_state == 2));
      if (re) sb.push_back(m_mem[ra]);
      case (m_state)
         0: if (st) begin
               m_rl = int'(row_last); m_pl = int'(pass_last); m_relu = relu_en;
               m_row = 0; m_pass = 0; m_state = 1;
            end
         1: if (v) begin
               m_pop(d);
               if (m_row == m_rl && m_pass == m_pl) m_state = 2;
               else if (m_row == m_rl) begin m_row = 0; m_pass++; end
               else m_row++;
            end
         default: m_state = 0;
      endcase
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 0, 1'b0);
   endtask

   task automatic read_rows(input int n);
      for (int r = 0; r < n; r++) step(1'b0, '0, 1'b1, r, 1'b0);
      idle(1);
   endtask

   task automatic begin_run(input int rl, input int pl, input logic re_lu);
      row_last = rl[3:0]; pass_last = pl[3:0]; relu_en = re_lu;
      step(1'b0, '0, 1'b0, 0, 1'b1);
   endtask

   initial begin
      logic [W-1:0] w;
      start = 0; row_last = 0; pass_last = 0; relu_en = 0;
      fifo_valid = 1; fifo_data = '1; rd_en = 0; rd_addr = 0;
      reset = 1;
      m_reset();
      #2;
      chk("rst_fifo_rd", W'(fifo_rd), '0);
      chk("rst_busy",    W'(busy),    '0);
      chk("rst_done",    W'(done),    '0);
      chk("rst_rd_data", rd_data,     '0);
      @(negedge clk);
      reset = 0;
      fifo_valid = 0;

      // single word, single pass
      begin_run(0, 0, 1'b0);
      step(1'b1, mk(5, 0), 1'b0, 0, 1'b0);
      idle(2);
      read_rows(1);
      chk("t1_row0", rd_data, {8{16'h0005}});

      // 4 rows x 3 passes, back-to-back pops
      begin_run(3, 2, 1'b0);
      for (int k = 0; k < 3; k++)
         for (int r = 0; r < 4; r++) step(1'b1, mk(r + k, 1), 1'b0, 0, 1'b0);
      idle(2);
      read_rows(4);
      step(1'b0, '0, 1'b1, 1, 1'b0);
      idle(1);
      chk("t2_r1_l0", W'(rd_data[15:0]),    W'(16'd6));
      chk("t2_r1_l7", W'(rd_data[127:112]), W'(16'd27));

      // saturation, without and with ReLU
      for (int rl = 0; rl < 2; rl++) begin
         begin_run(0, 1, rl[0]);
         w = '0; w[15:0] = 16'h7000; w[31:16] = 16'h9000;
         step(1'b1, w, 1'b0, 0, 1'b0);
         w = '0; w[15:0] = 16'h2000; w[31:16] = 16'hA000;
         step(1'b1, w, 1'b0, 0, 1'b0);
         idle(2);
         read_rows(1);
         chk("t3_sat", W'(rd_data[31:0]), rl == 0 ? W'(32'h8000_7FFF) : W'(32'h0000_7FFF));
      end

      // stalls, start mid-run, config changes mid-run, start in DONE
      begin_run(1, 0, 1'b0);
      step(1'b1, mk(-3, 1), 1'b0, 0, 1'b0);
      row_last = 4'd3; pass_last = 4'd3; relu_en = 1'b1;
      step(1'b0, mk(9, 0), 1'b0, 0, 1'b1);
      step(1'b0, mk(9, 0), 1'b0, 0, 1'b0);
      step(1'b1, mk(-7, 2), 1'b0, 0, 1'b0);
      step(1'b0, '0, 1'b0, 0, 1'b1);
      idle(2);
      read_rows(2);

      // read/write collision on row 2
      begin_run(3, 1, 1'b0);
      for (int r = 0; r < 4; r++) step(1'b1, mk(r * 5, 0), 1'b0, 0, 1'b0);
      for (int r = 0; r < 4; r++) begin
         step(1'b1, mk(4, 0), r == 2, 2, 1'b0);
         if (r == 3) chk("t5_old", W'(rd_data[15:0]), W'(16'd10));
      end
      idle(2);
      step(1'b0, '0, 1'b1, 2, 1'b0);
      idle(1);
      chk("t5_new", W'(rd_data[15:0]), W'(16'd14));

      // reset mid-run after 5 pops
      begin_run(3, 1, 1'b0);
      for (int r = 0; r < 5; r++) step(1'b1, mk(r + 1, 1), 1'b0, 0, 1'b0);
      @(negedge clk);
      fifo_valid = 1; reset = 1;
      #1;
      chk("t6_fifo_rd", W'(fifo_rd), '0);
      chk("t6_busy",    W'(busy),    '0);
      chk("t6_done",    W'(done),    '0);
      m_reset();
      @(negedge clk);
      chk("t6_done_hold", W'(done), '0);
      reset = 0;
      fifo_valid = 0;
      idle(2);
      read_rows(4);
      begin_run(1, 1, 1'b1);
      for (int k = 0; k < 2; k++)
         for (int r = 0; r < 2; r++) step(1'b1, mk(r - 2 * k, 1), 1'b0, 0, 1'b0);
      idle(2);
      read_rows(2);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
